// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the GPU DRAM responder: default memory window,
// clear-engine state encoding and the byte-address to word-index helper.
package gpu_mem_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'h1000_0000;
    localparam int          DEFAULT_DEPTH_WORDS = 327680;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    // Byte address to word index relative to the window base; the low two
    // address bits fall out of the shift, so sub-word offsets are ignored.
    function automatic logic [31:0] addr_to_idx(input logic [31:0] addr,
                                                input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/gpu_sdp_ram.sv
// Simple dual-port word RAM: one write port, one registered read port.
// A read and a write to the same word in the same cycle returns the old word.
module gpu_sdp_ram #(
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port; storage is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; the non-blocking update gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/gpu_dram_responder.sv
// On-chip stand-in for the GPU's DRAM port: a word memory mapped at BASE_ADDR
// with 1-cycle read latency, a range-fill clear engine and an out-of-window
// error flag. Defining GPU_DRAM_RESP_STATS_EN builds the write/read access
// counters; otherwise both counter outputs are tied to zero.
module gpu_dram_responder
    import gpu_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int          DATA_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_dram_we,
    input  logic [31:0]           i_dram_addr,
    input  logic [DATA_WIDTH-1:0] i_dram_wdata,
    output logic [DATA_WIDTH-1:0] o_dram_rdata,
    input  logic                  i_clr_start,
    input  logic [31:0]           i_clr_base,
    input  logic [31:0]           i_clr_len,
    input  logic [DATA_WIDTH-1:0] i_clr_value,
    output logic                  o_clr_busy,
    output logic                  o_clr_done,
    output logic                  o_oob_err,
    output logic [31:0]           o_wr_count,
    output logic [31:0]           o_rd_count
);

    localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH_WORDS);

    logic [31:0]           gpu_idx;
    logic                  gpu_in_win;
    logic                  gpu_wr;
    logic                  gpu_rd;

    clr_state_t            state_q, state_d;
    logic [31:0]           ptr_q, ptr_d;
    logic [31:0]           end_q, end_d;
    logic [DATA_WIDTH-1:0] value_q, value_d;
    logic [32:0]           clr_sum;
    logic [31:0]           clr_end_sat;
    logic                  clr_wr;

    logic                  ram_we;
    logic [AW-1:0]         ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  rd_ok_q;
    logic                  oob_q;

    assign gpu_idx    = addr_to_idx(i_dram_addr, BASE_ADDR);
    assign gpu_in_win = (i_dram_addr >= BASE_ADDR) && (gpu_idx < DEPTH_W);
    assign gpu_wr     = i_dram_we && gpu_in_win;
    assign gpu_rd     = !i_dram_we && gpu_in_win;

    // The end index is formed in 33 bits so a wrapping base+len saturates to the depth.
    assign clr_sum     = {1'b0, i_clr_base} + {1'b0, i_clr_len};
    assign clr_end_sat = (clr_sum > {1'b0, DEPTH_W}) ? DEPTH_W : clr_sum[31:0];

    // Clear engine next-state logic; an in-window GPU write owns the write port and stalls it.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        end_d   = end_q;
        value_d = value_q;
        clr_wr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_clr_start) begin
                    ptr_d   = i_clr_base;
                    end_d   = clr_end_sat;
                    value_d = i_clr_value;
                    state_d = (i_clr_base >= clr_end_sat) ? DONE : CLEAR;
                end
            end
            CLEAR: begin
                if (!gpu_wr && !rst) begin
                    clr_wr = 1'b1;
                    ptr_d  = ptr_q + 32'd1;
                    if (ptr_d == end_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Clear engine state register; reset abandons any clear in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            end_q   <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            end_q   <= end_d;
            value_q <= value_d;
        end
    end

    assign o_clr_busy = (state_q != IDLE);
    assign o_clr_done = (state_q == DONE);

    assign ram_we    = gpu_wr || clr_wr;
    assign ram_waddr = gpu_wr ? gpu_idx[AW-1:0] : ptr_q[AW-1:0];
    assign ram_wdata = gpu_wr ? i_dram_wdata : value_q;

    gpu_sdp_ram #(
        .DEPTH      (DEPTH_WORDS),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (gpu_rd),
        .raddr (gpu_idx[AW-1:0]),
        .rdata (ram_rdata)
    );

    // Remembers whether last cycle was an in-window read so writes and misses return zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ok_q <= 1'b0;
        end else begin
            rd_ok_q <= gpu_rd;
        end
    end

    assign o_dram_rdata = rd_ok_q ? ram_rdata : '0;

    // Sticky error flag for any GPU access that falls outside the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            oob_q <= 1'b0;
        end else if (!gpu_in_win) begin
            oob_q <= 1'b1;
        end
    end

    assign o_oob_err = oob_q;

`ifdef GPU_DRAM_RESP_STATS_EN
    logic [31:0] wr_cnt_q;
    logic [31:0] rd_cnt_q;

    // Free-running access counters that wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (gpu_wr) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
            if (gpu_rd) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
        end
    end

    assign o_wr_count = wr_cnt_q;
    assign o_rd_count = rd_cnt_q;
`else
    assign o_wr_count = '0;
    assign o_rd_count = '0;
`endif

endmodule

// File: tb/tb_gpu_dram_responder.sv
// Self-checking bench for gpu_dram_responder: random GPU traffic against a
// sparse word model, plus directed clear-engine scenarios.
module tb_gpu_dram_responder;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 327680;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        we        = 1'b0;
    logic [31:0] addr      = BASE;
    logic [31:0] wdata     = '0;
    logic [31:0] rdata;
    logic        clr_start = 1'b0;
    logic [31:0] clr_base  = '0;
    logic [31:0] clr_len   = '0;
    logic [31:0] clr_value = '0;
    logic        clr_busy;
    logic        clr_done;
    logic        oob_err;
    logic [31:0] wr_count;
    logic [31:0] rd_count;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mem_m [int];
    logic [31:0] m_wr = '0;
    logic [31:0] m_rd = '0;
    bit          m_oob = 1'b0;
    logic [31:0] exp_rdata;
    bit          exp_known;

    gpu_dram_responder dut (
        .clk          (clk),
        .rst          (rst),
        .i_dram_we    (we),
        .i_dram_addr  (addr),
        .i_dram_wdata (wdata),
        .o_dram_rdata (rdata),
        .i_clr_start  (clr_start),
        .i_clr_base   (clr_base),
        .i_clr_len    (clr_len),
        .i_clr_value  (clr_value),
        .o_clr_busy   (clr_busy),
        .o_clr_done   (clr_done),
        .o_oob_err    (oob_err),
        .o_wr_count   (wr_count),
        .o_rd_count   (rd_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit in_win(input logic [31:0] a);
        longint off;
        off = longint'({32'd0, a}) - longint'({32'd0, BASE});
        return (off >= 0) && ((off / 4) < longint'(DEPTH));
    endfunction

    function automatic int widx(input logic [31:0] a);
        longint off;
        off = longint'({32'd0, a}) - longint'({32'd0, BASE});
        return int'(off / 4);
    endfunction

    function automatic logic [31:0] waddr(input int i);
        return BASE + 32'(i * 4);
    endfunction

    function automatic logic [31:0] cnt_exp(input logic [31:0] v);
`ifdef GPU_DRAM_RESP_STATS_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1; clr_start = 1'b0; we = 1'b0; addr = BASE; wdata = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_wr = '0; m_rd = '0; m_oob = 1'b0;
    endtask

    // One GPU request cycle; records what the response should be.
    task automatic gpu_op(input bit w, input logic [31:0] a, input logic [31:0] d);
        we = w; addr = a; wdata = d;
        exp_rdata = '0; exp_known = 1'b1;
        if (!in_win(a)) begin
            m_oob = 1'b1;
        end else if (w) begin
            mem_m[widx(a)] = d;
            m_wr++;
        end else begin
            m_rd++;
            if (mem_m.exists(widx(a))) exp_rdata = mem_m[widx(a)];
            else exp_known = 1'b0;
        end
        @(posedge clk); #1;
        clr_start = 1'b0;
    endtask

    task automatic idle_op();
        gpu_op(1'b0, BASE, '0);
    endtask

    // Starts a clear and returns the cycle (start = cycle 0) of the done pulse, -1 on timeout.
    task automatic run_clear(input logic [31:0] b, input logic [31:0] l, input logic [31:0] v,
                             input logic [15:0] stall_mask, input int restart_at,
                             output int done_cyc);
        longint e;
        int     c;
        int     sidx;
        e = longint'({32'd0, b}) + longint'({32'd0, l});
        if (e > longint'(DEPTH)) e = longint'(DEPTH);
        sidx = int'(e) - 1;
        clr_base = b; clr_len = l; clr_value = v; clr_start = 1'b1;
        idle_op();
        c = 1;
        done_cyc = (clr_done === 1'b1) ? 1 : -1;
        while (done_cyc < 0 && c < 100) begin
            if (c == restart_at) begin
                clr_base = 32'd0; clr_len = 32'd1; clr_value = 32'hBAD0_BAD0; clr_start = 1'b1;
            end
            if (c < 16 && stall_mask[c[3:0]]) begin
                gpu_op(1'b1, waddr(sidx), 32'hBEEF_0000 + 32'(c));
                sidx--;
            end else begin
                idle_op();
            end
            c++;
            if (clr_done === 1'b1) done_cyc = c;
        end
        for (longint i = longint'({32'd0, b}); i < e; i++) mem_m[int'(i)] = v;
    endtask

    task automatic test_reset();
        gpu_op(1'b0, 32'h0000_0000, '0);
        gpu_op(1'b1, BASE + 32'd8, 32'h1111_2222);
        gpu_op(1'b0, BASE + 32'd8, '0);
        do_reset();
        total++; if (rdata !== 32'd0) begin bad++; $display("[TB] FAIL reset_rdata: got %h want %h", rdata, 32'd0); end
        total++; if (clr_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", clr_busy); end
        total++; if (clr_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", clr_done); end
        total++; if (oob_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_oob: got %b want 0", oob_err); end
        total++; if (wr_count !== 32'd0) begin bad++; $display("[TB] FAIL reset_wr_count: got %0d want 0", wr_count); end
        total++; if (rd_count !== 32'd0) begin bad++; $display("[TB] FAIL reset_rd_count: got %0d want 0", rd_count); end
    endtask

    task automatic test_write_read();
        do_reset();
        gpu_op(1'b1, 32'h1000_0018, 32'hFFFF_0000);
        total++; if (rdata !== 32'd0) begin bad++; $display("[TB] FAIL wr_cycle_rdata: got %h want 0", rdata); end
        total++; if (wr_count !== cnt_exp(m_wr)) begin bad++; $display("[TB] FAIL wr_count: got %0d want %0d", wr_count, cnt_exp(m_wr)); end
        gpu_op(1'b0, 32'h1000_0018, '0);
        total++; if (rdata !== 32'hFFFF_0000) begin bad++; $display("[TB] FAIL rd_after_wr: got %h want %h", rdata, 32'hFFFF_0000); end
        total++; if (rd_count !== cnt_exp(m_rd)) begin bad++; $display("[TB] FAIL rd_count: got %0d want %0d", rd_count, cnt_exp(m_rd)); end
        gpu_op(1'b0, 32'h1000_001B, '0);
        total++; if (rdata !== exp_rdata) begin bad++; $display("[TB] FAIL rd_low_bits: got %h want %h", rdata, exp_rdata); end
    endtask

    task automatic test_oob();
        gpu_op(1'b0, 32'h0FFF_FFFC, '0);
        total++; if (rdata !== 32'd0) begin bad++; $display("[TB] FAIL oob_below_rdata: got %h want 0", rdata); end
        total++; if (oob_err !== 1'b1) begin bad++; $display("[TB] FAIL oob_below_flag: got %b want 1", oob_err); end
        gpu_op(1'b0, BASE + 32'(4 * DEPTH), '0);
        total++; if (rdata !== 32'd0) begin bad++; $display("[TB] FAIL oob_above_rdata: got %h want 0", rdata); end
        gpu_op(1'b1, BASE + 32'(4 * DEPTH), 32'hDEAD_DEAD);
        gpu_op(1'b0, 32'h1000_0018, '0);
        total++; if (rdata !== exp_rdata) begin bad++; $display("[TB] FAIL oob_valid_after: got %h want %h", rdata, exp_rdata); end
        total++; if (oob_err !== 1'b1) begin bad++; $display("[TB] FAIL oob_sticky: got %b want 1", oob_err); end
        total++; if (wr_count !== cnt_exp(m_wr)) begin bad++; $display("[TB] FAIL oob_wr_dropped: got %0d want %0d", wr_count, cnt_exp(m_wr)); end
    endtask

    task automatic test_random();
        int          pool [16] = '{0, 1, 2, 6, 100, 1023, 4096, 16383, 50000, 65535,
                                   100000, 200000, 300000, 327000, 327678, 327679};
        logic [31:0] a;
        int          r;
        int          nbad;
        foreach (pool[k]) gpu_op(1'b1, waddr(pool[k]), $urandom);
        nbad = 0;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 15) begin
                case ($urandom_range(0, 2))
                    0:       a = $urandom_range(0, 32'h0FFF_FFFF);
                    1:       a = BASE + 32'(4 * DEPTH) + $urandom_range(0, 4095);
                    default: a = 32'hF000_0000 + $urandom_range(0, 32'h0FFF_FFFF);
                endcase
                gpu_op($urandom_range(0, 1) == 1, a, $urandom);
            end else begin
                a = waddr(pool[$urandom_range(0, 15)]) | 32'($urandom_range(0, 3));
                gpu_op(r < 55, a, $urandom);
            end
            if (exp_known) begin
                total++;
                if (rdata !== exp_rdata) begin
                    bad++;
                    if (nbad < 5) $display("[TB] FAIL rand_rdata: got %h want %h addr %h", rdata, exp_rdata, a);
                    nbad++;
                end
            end
        end
        total++; if (wr_count !== cnt_exp(m_wr)) begin bad++; $display("[TB] FAIL rand_wr_count: got %0d want %0d", wr_count, cnt_exp(m_wr)); end
        total++; if (rd_count !== cnt_exp(m_rd)) begin bad++; $display("[TB] FAIL rand_rd_count: got %0d want %0d", rd_count, cnt_exp(m_rd)); end
        total++; if (oob_err !== m_oob) begin bad++; $display("[TB] FAIL rand_oob: got %b want %b", oob_err, m_oob); end
    endtask

    task automatic test_clear();
        int dc;
        gpu_op(1'b1, waddr(16383), 32'h0000_ABCD);
        gpu_op(1'b1, waddr(16392), 32'h1234_5678);
        run_clear(32'd16384, 32'd8, 32'h0000_00FF, 16'h0000, 3, dc);
        total++; if (dc != 9) begin bad++; $display("[TB] FAIL clear_done_cycle: got %0d want 9", dc); end
        idle_op();
        total++; if (clr_done !== 1'b0 || clr_busy !== 1'b0) begin bad++; $display("[TB] FAIL clear_pulse_end: got done=%b busy=%b want 0 0", clr_done, clr_busy); end
        for (int i = 16383; i <= 16392; i++) begin
            gpu_op(1'b0, waddr(i), '0);
            total++; if (!exp_known || rdata !== exp_rdata) begin bad++; $display("[TB] FAIL clear_readback[%0d]: got %h want %h", i, rdata, exp_rdata); end
        end
    endtask

    task automatic test_clear_stall();
        int dc;
        run_clear(32'd16384, 32'd8, 32'h0000_00FF, 16'b0000_0000_0010_1010, -1, dc);
        total++; if (dc != 12) begin bad++; $display("[TB] FAIL stall_done_cycle: got %0d want 12", dc); end
        for (int i = 16384; i <= 16392; i++) begin
            gpu_op(1'b0, waddr(i), '0);
            total++; if (!exp_known || rdata !== exp_rdata) begin bad++; $display("[TB] FAIL stall_readback[%0d]: got %h want %h", i, rdata, exp_rdata); end
        end
    endtask

    task automatic test_read_first();
        int n;
        for (int i = 0; i < 4; i++) gpu_op(1'b1, waddr(20000 + i), 32'h2000_0000 + 32'(i));
        clr_base = 32'd20000; clr_len = 32'd4; clr_value = 32'hFEED_FEED; clr_start = 1'b1;
        idle_op();
        gpu_op(1'b0, waddr(20000), '0);
        total++; if (rdata !== exp_rdata) begin bad++; $display("[TB] FAIL read_first_old: got %h want %h", rdata, exp_rdata); end
        gpu_op(1'b0, waddr(20000), '0);
        total++; if (rdata !== 32'hFEED_FEED) begin bad++; $display("[TB] FAIL read_after_clear: got %h want %h", rdata, 32'hFEED_FEED); end
        n = 0;
        while (clr_busy === 1'b1 && n < 20) begin idle_op(); n++; end
        total++; if (clr_busy !== 1'b0) begin bad++; $display("[TB] FAIL read_first_finish: got busy=%b want 0", clr_busy); end
        for (int i = 0; i < 4; i++) mem_m[20000 + i] = 32'hFEED_FEED;
    endtask

    task automatic test_clear_edges();
        int dc;
        do_reset();
        gpu_op(1'b1, waddr(5000), 32'h0000_0055);
        run_clear(32'd5000, 32'd0, 32'h0000_0077, 16'h0000, -1, dc);
        total++; if (dc != 1) begin bad++; $display("[TB] FAIL zero_len_done: got %0d want 1", dc); end
        gpu_op(1'b0, waddr(5000), '0);
        total++; if (rdata !== exp_rdata) begin bad++; $display("[TB] FAIL zero_len_untouched: got %h want %h", rdata, exp_rdata); end
        run_clear(32'(DEPTH - 4), 32'd100, 32'h0000_0099, 16'h0000, -1, dc);
        total++; if (dc != 5) begin bad++; $display("[TB] FAIL oversize_done: got %0d want 5", dc); end
        gpu_op(1'b0, waddr(DEPTH - 1), '0);
        total++; if (!exp_known || rdata !== exp_rdata) begin bad++; $display("[TB] FAIL oversize_last: got %h want %h", rdata, exp_rdata); end
        run_clear(32'(DEPTH + 10), 32'd5, 32'h0000_0011, 16'h0000, -1, dc);
        total++; if (dc != 1) begin bad++; $display("[TB] FAIL beyond_depth_done: got %0d want 1", dc); end
        idle_op();
        run_clear(32'(DEPTH - 2), 32'hFFFF_FFFF, 32'h0000_0022, 16'h0000, -1, dc);
        total++; if (dc != 3) begin bad++; $display("[TB] FAIL wrap_len_done: got %0d want 3", dc); end
        gpu_op(1'b0, waddr(DEPTH - 2), '0);
        total++; if (!exp_known || rdata !== exp_rdata) begin bad++; $display("[TB] FAIL wrap_len_word: got %h want %h", rdata, exp_rdata); end
        total++; if (oob_err !== m_oob) begin bad++; $display("[TB] FAIL clear_no_oob: got %b want %b", oob_err, m_oob); end
    endtask

    task automatic test_reset_mid_clear();
        int nd;
        int dc;
        for (int i = 0; i < 6; i++) gpu_op(1'b1, waddr(30000 + i), 32'h3000_0000 + 32'(i));
        clr_base = 32'd30000; clr_len = 32'd10; clr_value = 32'hC1EA_C1EA; clr_start = 1'b1;
        idle_op();
        repeat (3) idle_op();
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (clr_busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy: got %b want 0", clr_busy); end
        total++; if (clr_done !== 1'b0) begin bad++; $display("[TB] FAIL midrst_done: got %b want 0", clr_done); end
        rst = 1'b0;
        m_wr = '0; m_rd = '0; m_oob = 1'b0;
        for (int i = 0; i < 3; i++) mem_m[30000 + i] = 32'hC1EA_C1EA;
        nd = 0;
        repeat (12) begin idle_op(); if (clr_done !== 1'b0) nd++; end
        total++; if (nd != 0) begin bad++; $display("[TB] FAIL midrst_no_pulse: got %0d pulses want 0", nd); end
        gpu_op(1'b0, waddr(30002), '0);
        total++; if (rdata !== exp_rdata) begin bad++; $display("[TB] FAIL midrst_kept: got %h want %h", rdata, exp_rdata); end
        gpu_op(1'b0, waddr(30003), '0);
        total++; if (rdata !== exp_rdata) begin bad++; $display("[TB] FAIL midrst_stopped: got %h want %h", rdata, exp_rdata); end
        run_clear(32'd31000, 32'd2, 32'h0000_0001, 16'h0000, -1, dc);
        total++; if (dc != 3) begin bad++; $display("[TB] FAIL midrst_restart: got %0d want 3", dc); end
        idle_op();
        total++; if (rd_count !== cnt_exp(m_rd)) begin bad++; $display("[TB] FAIL midrst_rd_count: got %0d want %0d", rd_count, cnt_exp(m_rd)); end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_write_read();
        test_oob();
        test_random();
        test_clear();
        test_clear_stall();
        test_read_first();
        test_clear_edges();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpu_dram_responder.md
# gpu_dram_responder

Synthesizable responder for the GPU's simple DRAM port (`we`/`addr`/`wdata` out, `rdata` in). It holds an on-chip word memory mapped at a fixed base address and returns read data one cycle after the request. A built-in clear engine fills a word range with a constant so the framebuffer can be wiped between frames. It sits directly on `gpu_top`'s `o_dram_*`/`i_dram_rdata` pins and replaces off-chip DDR in small FPGA builds and in system benches.

## Interface
- `BASE_ADDR`, 32'h1000_0000: byte address of word 0.
- `DEPTH_WORDS`, 327680: memory depth in 32-bit words.
- `DATA_WIDTH`, 32: word width.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_dram_we` in 1: 1 = write, 0 = read. A request is presented every cycle; there is no valid signal.
- `i_dram_addr` in 32: byte address; bits [1:0] ignored.
- `i_dram_wdata` in DATA_WIDTH: write data.
- `o_dram_rdata` out DATA_WIDTH: registered read data.
- `i_clr_start` in 1: one-cycle pulse that starts a clear.
- `i_clr_base` in 32: first word index to clear.
- `i_clr_len` in 32: number of words to clear.
- `i_clr_value` in DATA_WIDTH: fill word.
- `o_clr_busy` out 1: clear engine active.
- `o_clr_done` out 1: one-cycle pulse when a clear finishes.
- `o_oob_err` out 1: sticky flag set by any out-of-window access.
- `o_wr_count` out 32: count of accepted GPU writes.
- `o_rd_count` out 32: count of in-window GPU reads.

## Operation
- Word index is `idx = (i_dram_addr - BASE_ADDR) >> 2`.
- An access is in-window when `i_dram_addr >= BASE_ADDR` and `idx < DEPTH_WORDS`.
- GPU write, in-window: `mem[idx] <= i_dram_wdata`. `o_wr_count` increments.
- GPU write, out-of-window: dropped. `o_oob_err` is set.
- GPU read, in-window: `o_dram_rdata <= mem[idx]`. `o_rd_count` increments.
- GPU read, out-of-window: `o_dram_rdata <= 0`. `o_oob_err` is set.
- On a write cycle, `o_dram_rdata <= 0`.
- Clear FSM states are IDLE, CLEAR and DONE.
  - IDLE → CLEAR on `i_clr_start`. Latch `ptr = i_clr_base` and `end = min(i_clr_base + i_clr_len, DEPTH_WORDS)`. The sum is computed in 33 bits, so overflow saturates to DEPTH_WORDS.
  - IDLE → DONE when `ptr >= end` at start, i.e. zero length or base beyond depth.
  - CLEAR: each cycle, write `mem[ptr] <= value` and increment `ptr`. When the incremented `ptr` reaches `end`, go to DONE.
  - DONE: assert `o_clr_done` for one cycle, then go to IDLE.
- Arbitration is on a single write port. An in-window GPU write wins; the clear engine stalls that cycle and `ptr` holds. GPU reads never stall the clear engine, because the RAM is simple dual-port.
- `i_clr_start` is ignored while `o_clr_busy` is high.
- A GPU read and a write to the same index in the same cycle returns the old data (read-first).
- `o_clr_busy` is high in CLEAR and DONE.

## Timing
- Read latency is exactly 1 cycle: `o_dram_rdata` in cycle N+1 reflects the address in cycle N.
- A write is visible to a read issued on the following cycle.
- Clear throughput is 1 word/cycle when unstalled. Total cycles from start to the done pulse = words written + stalls + 1.
- Reset values:
  - `o_dram_rdata` = 0, `o_clr_busy` = 0, `o_clr_done` = 0, `o_oob_err` = 0, both counters = 0.
  - FSM = IDLE.
  - Memory contents are not reset.
- Reset mid-clear aborts the clear immediately: no done pulse, and already-written words remain.
- Counters wrap modulo 2^32.

## Configuration
- `GPU_DRAM_RESP_STATS_EN` defined: `o_wr_count` and `o_rd_count` are implemented as described.
- `GPU_DRAM_RESP_STATS_EN` undefined: both are tied to 0, no counter flops are built, and `o_oob_err` is unaffected.

## Structure
- Package `gpu_mem_pkg`:
  - default `BASE_ADDR`;
  - `clr_state_t` enum (IDLE/CLEAR/DONE);
  - an `addr_to_idx` function.
- Sub-module `gpu_sdp_ram`: simple dual-port RAM with one write port and one registered read-first read port, with inference-friendly coding.

## Test plan
- Write 32'hFFFF0000 to 0x1000_0018, then read it on the next cycle → `o_dram_rdata` = 32'hFFFF0000 one cycle later, and `o_wr_count` = 1.
- Read 0x0FFF_FFFC, then read `BASE_ADDR + 4*DEPTH_WORDS` → `rdata` = 0 both times, `o_oob_err` = 1 and stays set.
- Clear base 16384, len 8, value 32'h0000_00FF with an idle GPU port → `o_clr_done` arrives 9 cycles after start; words 16384..16391 read back 0xFF and word 16392 is unchanged.
- Same clear with GPU writes in 3 of the clear cycles → the done pulse is delayed by 3 cycles, and GPU-written addresses inside the range end up holding the clear value.
- Clear with len 0, and a clear with base + len beyond the depth → the zero-length clear pulses done in 1 cycle; the oversized clear stops at DEPTH_WORDS-1 with no error.
- Assert `rst` mid-clear → `busy` = 0 on the next cycle, no done pulse, and a new start is accepted afterwards.
